cdb_arb: RTL and testbench

- Arbitrates among the execution units' result-return channels (exu side of exu2cdb_itf) and drives the single common data bus (mst side of cdb_itf).
- Sits between the execution units and all CDB consumers (register file unit, reservation stations, ROB).
- Grants at most one result per cycle using round-robin priority.
- Broadcasts the granted tag/data from a registered output stage one cycle later.

---
 rtl/cdb_arb.sv | 82 ++++++++
 tb/tb_cdb_arb.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/cdb_arb.sv
// Round-robin arbiter for execution-unit result channels onto the common data bus.
// The grant is combinational; the granted tag/data are broadcast from a register one cycle later.
module cdb_arb #(
  parameter int N_REQ = 4,
  parameter int TAG_W = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [N_REQ-1:0]       exu_req,
  input  logic [N_REQ*TAG_W-1:0] exu_tag,
  input  logic [N_REQ*32-1:0]    exu_wdata,
  output logic [N_REQ-1:0]       exu_rdy,
  output logic                   cdb_wr,
  output logic [TAG_W-1:0]       cdb_tag,
  output logic [31:0]            cdb_wdata
);

  localparam int DATA_W = 32;

  logic [PTR_W-1:0]  rr_ptr;
  logic [N_REQ-1:0]  gnt;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  scan_idx;
  logic              gnt_any;
  logic              xfer;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_data;

  logic              vld_p1;
  logic [TAG_W-1:0]  tag_p1;
  logic [DATA_W-1:0] data_p1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // Stage p0: scan from rr_ptr upward, wrapping, and grant the first requester
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr) + k) % N_REQ);
      if (!gnt_any && exu_req[scan_idx]) begin
        gnt[scan_idx] = 1'b1;
        gnt_idx       = scan_idx;
        gnt_any       = 1'b1;
      end
    end
  end

  // rst outranks flush, and both suppress any grant in the current cycle
  assign exu_rdy  = (rst || flush) ? '0 : gnt;
  assign xfer     = |exu_rdy;
  assign sel_tag  = exu_tag[int'(gnt_idx)*TAG_W +: TAG_W];
  assign sel_data = exu_wdata[int'(gnt_idx)*DATA_W +: DATA_W];

  // Stage p1: registered broadcast; tag/data hold when idle and are qualified by cdb_wr
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      vld_p1  <= 1'b0;
      tag_p1  <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= xfer;
      if (xfer) begin
        rr_ptr  <= ptr_inc(gnt_idx);
        tag_p1  <= sel_tag;
        data_p1 <= sel_data;
      end
    end
  end

  assign cdb_wr    = vld_p1;
  assign cdb_tag   = tag_p1;
  assign cdb_wdata = data_p1;

endmodule

// File: tb/tb_cdb_arb.sv
// Directed bench for cdb_arb: reset, single grant, wrap-around, flush, idle hold,
// full contention rotation and reset in the middle of contention.
module tb_cdb_arb;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [3:0]  exu_req;
  logic [15:0] exu_tag;
  logic [127:0] exu_wdata;
  logic [3:0]  exu_rdy;
  logic        cdb_wr;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_wdata;

  int checks = 0;
  int errors = 0;

  cdb_arb #(.N_REQ(4), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .exu_req   (exu_req),
    .exu_tag   (exu_tag),
    .exu_wdata (exu_wdata),
    .exu_rdy   (exu_rdy),
    .cdb_wr    (cdb_wr),
    .cdb_tag   (cdb_tag),
    .cdb_wdata (cdb_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic set_unit(input int i, input logic [3:0] t, input logic [31:0] d);
    exu_tag[i*4 +: 4]    = t;
    exu_wdata[i*32 +: 32] = d;
  endtask

  // Inputs are applied at the falling edge; grant checked 1 time unit later,
  // registered outputs checked at the next falling edge.
  task automatic step(input string name, input logic [3:0] rdy_exp, input logic wr_exp,
                      input logic [3:0] tag_exp, input logic [31:0] data_exp,
                      input logic [1:0] ptr_exp);
    #1;
    chk({name, " rdy"}, 64'(exu_rdy), 64'(rdy_exp));
    @(posedge clk);
    @(negedge clk);
    chk({name, " wr"}, 64'(cdb_wr), 64'(wr_exp));
    chk({name, " tag"}, 64'(cdb_tag), 64'(tag_exp));
    chk({name, " wdata"}, 64'(cdb_wdata), 64'(data_exp));
    chk({name, " ptr"}, 64'(dut.rr_ptr), 64'(ptr_exp));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("onehot0", 64'($onehot0(exu_rdy)), 64'd1);
      chk("subset", 64'(exu_rdy & ~exu_req), 64'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    exu_req   = 4'b1111;
    exu_tag   = '0;
    exu_wdata = '0;

    // Reset for two cycles with all units requesting
    step("reset0", 4'b0000, 1'b0, 4'h0, 32'h0, 2'd0);
    step("reset1", 4'b0000, 1'b0, 4'h0, 32'h0, 2'd0);

    // Single request from unit 2
    rst     = 1'b0;
    exu_req = 4'b0100;
    set_unit(2, 4'h5, 32'hDEAD_BEEF);
    step("single", 4'b0100, 1'b1, 4'h5, 32'hDEAD_BEEF, 2'd3);
    exu_req = 4'b0000;
    step("single_idle", 4'b0000, 1'b0, 4'h5, 32'hDEAD_BEEF, 2'd3);

    // Wrap-around from rr_ptr=3 with units 0 and 1 requesting
    exu_req = 4'b0011;
    set_unit(0, 4'hA, 32'hAAAA_0000);
    set_unit(1, 4'hB, 32'hBBBB_1111);
    step("wrap0", 4'b0001, 1'b1, 4'hA, 32'hAAAA_0000, 2'd1);
    step("wrap1", 4'b0010, 1'b1, 4'hB, 32'hBBBB_1111, 2'd2);

    // Flush kills the grant; the broadcast already showing stays visible
    exu_req = 4'b0010;
    flush   = 1'b1;
    set_unit(1, 4'hC, 32'hCCCC_2222);
    chk("flush visible wr", 64'(cdb_wr), 64'd1);
    step("flush", 4'b0000, 1'b0, 4'hB, 32'hBBBB_1111, 2'd2);
    flush = 1'b0;
    step("post_flush", 4'b0010, 1'b1, 4'hC, 32'hCCCC_2222, 2'd2);

    // Idle hold of the last broadcast
    exu_req = 4'b0100;
    set_unit(2, 4'h7, 32'h1234_5678);
    step("hold_xfer", 4'b0100, 1'b1, 4'h7, 32'h1234_5678, 2'd3);
    exu_req = 4'b0000;
    for (int n = 0; n < 3; n++)
      step("hold_idle", 4'b0000, 1'b0, 4'h7, 32'h1234_5678, 2'd3);

    // Bring rr_ptr back to 0 via unit 3
    exu_req = 4'b1000;
    set_unit(3, 4'h3, 32'h0000_0103);
    step("align", 4'b1000, 1'b1, 4'h3, 32'h0000_0103, 2'd0);

    // Full contention: grants rotate 0,1,2,3,0,1
    exu_req = 4'b1111;
    for (int u = 0; u < 4; u++) set_unit(u, 4'(u), 32'h100 + 32'(u));
    for (int k = 0; k < 6; k++) begin
      int g;
      g = k % 4;
      step("rotate", 4'(1 << g), 1'b1, 4'(g), 32'h100 + 32'(g), 2'((g + 1) % 4));
    end

    // Reset mid-stream at rr_ptr=2, then arbitration restarts at unit 0
    rst = 1'b1;
    step("mid_reset", 4'b0000, 1'b0, 4'h0, 32'h0, 2'd0);
    rst = 1'b0;
    step("after_reset", 4'b0001, 1'b1, 4'h0, 32'h100, 2'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
